// File: rtl/write_back_stage.sv
// write_back_stage: final pipeline stage. It picks the write-back value and
// destination register from the MEM-stage candidates and registers them onto
// the register-file write port. It also counts committed register writes.
//
// Optional feature, selected by macro WB_LOAD_EXT_EN:
//   defined   - memory results are narrowed to a byte or half by byte_off_in
//               (little-endian), then sign- or zero-extended per load_type_in.
//   undefined - mem_data_in passes unmodified; load_type_in and byte_off_in
//               are ignored.
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   in_valid           MEM-stage result present this cycle
//   stall, flush       hold / squash the stage (flush wins)
//   reg_write_in       instruction writes a register
//   alu_result_in, mem_data_in, link_pc_in   candidate write-back values
//   wb_data_sel_in     00 ALU, 01 memory, 10 link PC, 11 ALU
//   wb_addr1_in, wb_addr2_in, wb_addr_sel_in destination select
//                      (00 addr1, 01 addr2, 10 link register, 11 addr1)
//   load_type_in, byte_off_in                load width/sign and lane
//   wb_we, wb_addr, wb_data                  register-file write port
//   retire_cnt         number of committed register writes (wraps)
module write_back_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               stall,
    input  logic               flush,
    input  logic               reg_write_in,
    input  logic [DATA_W-1:0]  alu_result_in,
    input  logic [DATA_W-1:0]  mem_data_in,
    input  logic [DATA_W-1:0]  link_pc_in,
    input  logic [1:0]         wb_data_sel_in,
    input  logic [RADDR_W-1:0] wb_addr1_in,
    input  logic [RADDR_W-1:0] wb_addr2_in,
    input  logic [1:0]         wb_addr_sel_in,
    input  logic [2:0]         load_type_in,
    input  logic [1:0]         byte_off_in,
    output logic               wb_we,
    output logic [RADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic [31:0]        retire_cnt
);

    localparam int unsigned CNT_W = 32;

    localparam logic [2:0] LT_BYTE_S = 3'b001;
    localparam logic [2:0] LT_BYTE_U = 3'b010;
    localparam logic [2:0] LT_HALF_S = 3'b011;
    localparam logic [2:0] LT_HALF_U = 3'b100;

    logic [RADDR_W-1:0] addr_c;
    logic [DATA_W-1:0]  mem_ext_c;
    logic [DATA_W-1:0]  data_c;
    logic               we_c;

    // Destination register select; 10 targets the all-ones link register.
    always_comb begin
        addr_c = wb_addr1_in;
        case (wb_addr_sel_in)
            2'b01:   addr_c = wb_addr2_in;
            2'b10:   addr_c = '1;
            default: addr_c = wb_addr1_in;
        endcase
    end

`ifdef WB_LOAD_EXT_EN
    logic [7:0]  ld_byte_c;
    logic [15:0] ld_half_c;

    // Lane extraction and extension of the loaded memory word.
    always_comb begin
        ld_byte_c = mem_data_in[{byte_off_in, 3'b000} +: 8];
        ld_half_c = byte_off_in[1] ? mem_data_in[31:16] : mem_data_in[15:0];
        mem_ext_c = mem_data_in;
        case (load_type_in)
            LT_BYTE_S: mem_ext_c = {{(DATA_W-8){ld_byte_c[7]}}, ld_byte_c};
            LT_BYTE_U: mem_ext_c = {{(DATA_W-8){1'b0}}, ld_byte_c};
            LT_HALF_S: mem_ext_c = {{(DATA_W-16){ld_half_c[15]}}, ld_half_c};
            LT_HALF_U: mem_ext_c = {{(DATA_W-16){1'b0}}, ld_half_c};
            default:   mem_ext_c = mem_data_in;
        endcase
    end
`else
    // Load shaping inputs have no effect in this build.
    logic unused_load_c;
    assign unused_load_c = ^{load_type_in, byte_off_in, LT_BYTE_S, LT_BYTE_U,
                             LT_HALF_S, LT_HALF_U};
    assign mem_ext_c = mem_data_in;
`endif

    // Write-back value select; extension only ever applies to memory data.
    always_comb begin
        data_c = alu_result_in;
        case (wb_data_sel_in)
            2'b01:   data_c = mem_ext_c;
            2'b10:   data_c = link_pc_in;
            default: data_c = alu_result_in;
        endcase
    end

    // Register 0 is hard-wired, so a write to it is never committed.
    assign we_c = in_valid & reg_write_in & (addr_c != '0);

    // Pipeline register and retire counter; flush overrides stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            retire_cnt <= '0;
        end else if (flush) begin
            wb_we <= 1'b0;
        end else if (!stall) begin
            wb_we   <= we_c;
            wb_addr <= addr_c;
            wb_data <= data_c;
            if (we_c) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_write_back_stage.sv
// Table-driven bench for write_back_stage with a scoreboard queue, plus
// hand-written stall/flush and asynchronous-reset sequences.
module tb_write_back_stage;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned NVEC    = 13;

`ifdef WB_LOAD_EXT_EN
    localparam logic [31:0] X_BS2 = 32'hFFFFFFFF;
    localparam logic [31:0] X_HU2 = 32'h000080FF;
    localparam logic [31:0] X_HS2 = 32'hFFFF80FF;
    localparam logic [31:0] X_BU3 = 32'h00000080;
`else
    localparam logic [31:0] X_BS2 = 32'h80FF7F01;
    localparam logic [31:0] X_HU2 = 32'h80FF7F01;
    localparam logic [31:0] X_HS2 = 32'h80FF7F01;
    localparam logic [31:0] X_BU3 = 32'h80FF7F01;
`endif

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               stall;
    logic               flush;
    logic               reg_write_in;
    logic [DATA_W-1:0]  alu_result_in;
    logic [DATA_W-1:0]  mem_data_in;
    logic [DATA_W-1:0]  link_pc_in;
    logic [1:0]         wb_data_sel_in;
    logic [RADDR_W-1:0] wb_addr1_in;
    logic [RADDR_W-1:0] wb_addr2_in;
    logic [1:0]         wb_addr_sel_in;
    logic [2:0]         load_type_in;
    logic [1:0]         byte_off_in;
    logic               wb_we;
    logic [RADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic [31:0]        retire_cnt;

    write_back_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .stall          (stall),
        .flush          (flush),
        .reg_write_in   (reg_write_in),
        .alu_result_in  (alu_result_in),
        .mem_data_in    (mem_data_in),
        .link_pc_in     (link_pc_in),
        .wb_data_sel_in (wb_data_sel_in),
        .wb_addr1_in    (wb_addr1_in),
        .wb_addr2_in    (wb_addr2_in),
        .wb_addr_sel_in (wb_addr_sel_in),
        .load_type_in   (load_type_in),
        .byte_off_in    (byte_off_in),
        .wb_we          (wb_we),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .retire_cnt     (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        rw;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] link;
        logic [1:0]  dsel;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [1:0]  asel;
        logic [2:0]  lt;
        logic [1:0]  bo;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    vec_t        vecs [NVEC];
    exp_t        sb [$];
    int          checks;
    int          errors;
    logic [31:0] exp_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid       = v.valid;
        reg_write_in   = v.rw;
        alu_result_in  = v.alu;
        mem_data_in    = v.mem;
        link_pc_in     = v.link;
        wb_data_sel_in = v.dsel;
        wb_addr1_in    = v.a1;
        wb_addr2_in    = v.a2;
        wb_addr_sel_in = v.asel;
        load_type_in   = v.lt;
        byte_off_in    = v.bo;
    endtask

    task automatic check_all(input string tag, input logic we, input logic [4:0] addr,
                             input logic [31:0] data, input logic [31:0] cnt);
        check({tag, ".we"},   32'(wb_we),   32'(we));
        check({tag, ".addr"}, 32'(wb_addr), 32'(addr));
        check({tag, ".data"}, wb_data,      data);
        check({tag, ".cnt"},  retire_cnt,   cnt);
    endtask

    // Pop the oldest expected result and compare it with the DUT output.
    task automatic sb_compare(input string tag);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s.sb: got empty scoreboard expected one entry", tag);
        end else begin
            e = sb.pop_front();
            check_all(tag, e.we, e.addr, e.data, exp_cnt);
        end
    endtask

    initial begin
        vec_t v;
        exp_t e;
        checks  = 0;
        errors  = 0;
        exp_cnt = 32'd0;

        //          vld   rw    alu           mem           link          dsel   a1     a2     asel   lt      bo     we    addr    data
        vecs[0]  = '{1'b1, 1'b1, 32'h12345678, 32'h0,        32'h0,        2'b00, 5'd5,  5'd0,  2'b00, 3'b000, 2'd0, 1'b1, 5'd5,  32'h12345678};
        vecs[1]  = '{1'b1, 1'b1, 32'h11111111, 32'h0,        32'h00400008, 2'b10, 5'd3,  5'd4,  2'b10, 3'b000, 2'd0, 1'b1, 5'd31, 32'h00400008};
        vecs[2]  = '{1'b1, 1'b1, 32'h0,        32'h80FF7F01, 32'h0,        2'b01, 5'd1,  5'd7,  2'b01, 3'b001, 2'd2, 1'b1, 5'd7,  X_BS2};
        vecs[3]  = '{1'b1, 1'b1, 32'h0,        32'h80FF7F01, 32'h0,        2'b01, 5'd8,  5'd7,  2'b00, 3'b100, 2'd2, 1'b1, 5'd8,  X_HU2};
        vecs[4]  = '{1'b1, 1'b1, 32'h0,        32'h80FF7F01, 32'h0,        2'b01, 5'd9,  5'd2,  2'b00, 3'b011, 2'd2, 1'b1, 5'd9,  X_HS2};
        vecs[5]  = '{1'b1, 1'b1, 32'h0,        32'h80FF7F01, 32'h0,        2'b01, 5'd10, 5'd2,  2'b00, 3'b010, 2'd3, 1'b1, 5'd10, X_BU3};
        vecs[6]  = '{1'b1, 1'b1, 32'h0,        32'h80FF7F01, 32'h0,        2'b01, 5'd11, 5'd2,  2'b00, 3'b000, 2'd1, 1'b1, 5'd11, 32'h80FF7F01};
        vecs[7]  = '{1'b1, 1'b1, 32'hAAAA5555, 32'h0,        32'h0,        2'b00, 5'd0,  5'd6,  2'b00, 3'b000, 2'd0, 1'b0, 5'd0,  32'hAAAA5555};
        vecs[8]  = '{1'b0, 1'b1, 32'h00000001, 32'h0,        32'h0,        2'b00, 5'd9,  5'd6,  2'b00, 3'b000, 2'd0, 1'b0, 5'd9,  32'h00000001};
        vecs[9]  = '{1'b1, 1'b0, 32'h0BADF00D, 32'h0,        32'h0,        2'b00, 5'd3,  5'd6,  2'b00, 3'b000, 2'd0, 1'b0, 5'd3,  32'h0BADF00D};
        vecs[10] = '{1'b1, 1'b1, 32'hDEADBEEF, 32'h0,        32'h77777777, 2'b11, 5'd12, 5'd4,  2'b11, 3'b000, 2'd0, 1'b1, 5'd12, 32'hDEADBEEF};
        vecs[11] = '{1'b1, 1'b1, 32'h0,        32'h12345678, 32'h0,        2'b01, 5'd13, 5'd20, 2'b01, 3'b111, 2'd1, 1'b1, 5'd20, 32'h12345678};
        vecs[12] = '{1'b1, 1'b1, 32'h0,        32'h0,        32'h0,        2'b00, 5'd0,  5'd0,  2'b10, 3'b000, 2'd0, 1'b1, 5'd31, 32'h0};

        // Reset held across clock edges
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset", 1'b0, 5'd0, 32'h0, 32'h0);
        rst_n = 1'b1;

        // Table: one vector per cycle, expectation queued at drive time
        for (int i = 0; i < NVEC; i++) begin
            v = vecs[i];
            drive(v);
            e.we   = v.exp_we;
            e.addr = v.exp_addr;
            e.data = v.exp_data;
            sb.push_back(e);
            if (v.exp_we) exp_cnt = exp_cnt + 32'd1;
            @(posedge clk);
            @(negedge clk);
            sb_compare($sformatf("vec%0d", i));
        end

        // Stall: outputs frozen for three cycles while inputs change
        drive(vecs[0]);
        exp_cnt = exp_cnt + 32'd1;
        @(posedge clk);
        @(negedge clk);
        check_all("pre_stall", 1'b1, 5'd5, 32'h12345678, exp_cnt);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            alu_result_in  = $urandom;
            wb_addr1_in    = 5'(k + 14);
            wb_data_sel_in = 2'(k);
            @(posedge clk);
            @(negedge clk);
            check_all($sformatf("stall%0d", k), 1'b1, 5'd5, 32'h12345678, exp_cnt);
        end

        // Flush beats stall: write-enable drops, address and data hold
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all("flush_stall", 1'b0, 5'd5, 32'h12345678, exp_cnt);
        flush = 1'b0;
        stall = 1'b0;

        // Reset asserted mid-cycle while a write is on the port
        v = vecs[0];
        v.a1  = 5'd6;
        v.alu = 32'h00000055;
        drive(v);
        @(posedge clk);
        #2;
        check_all("pre_reset", 1'b1, 5'd6, 32'h00000055, exp_cnt + 32'd1);
        rst_n = 1'b0;
        #1;
        exp_cnt = 32'd0;
        check_all("async_reset", 1'b0, 5'd0, 32'h0, exp_cnt);
        @(posedge clk);
        @(negedge clk);
        check_all("reset_hold", 1'b0, 5'd0, 32'h0, exp_cnt);
        rst_n = 1'b1;
        exp_cnt = exp_cnt + 32'd1;
        @(posedge clk);
        @(negedge clk);
        check_all("post_reset", 1'b1, 5'd6, 32'h00000055, exp_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
